// File: rtl/oled_spi_receiver.sv
// Receiver for the OLED manager's 4-wire serial bus: deserialises bytes, decodes
// SetX/SetY/SetPixel and emits one registered pixel-write strobe per 16-bit colour.
module oled_spi_receiver #(
  parameter int ColWidth = 7,
  parameter int RowWidth = 6,
  parameter int ColMax   = 95,
  parameter int RowMax   = 63
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                nCS,
  input  logic                DnC,
  input  logic                SDIN,
  input  logic                SCLK,
  input  logic                err_clear,
  output logic                pix_valid,
  output logic [ColWidth-1:0] pix_x,
  output logic [RowWidth-1:0] pix_y,
  output logic [15:0]         pix_colour,
  output logic                window_done,
  output logic                frame_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XSTART,
    ST_XEND,
    ST_YSTART,
    ST_YEND,
    ST_PIXHI,
    ST_PIXLO
  } state_e;

  localparam logic [7:0] CMD_SETX   = 8'h15;
  localparam logic [7:0] CMD_SETY   = 8'h75;
  localparam logic [7:0] CMD_SETPIX = 8'h5C;

  localparam logic [ColWidth-1:0] COL_END_RST = ColWidth'(ColMax);
  localparam logic [RowWidth-1:0] ROW_END_RST = RowWidth'(RowMax);
  localparam logic [ColWidth-1:0] COL_ONE     = ColWidth'(1);
  localparam logic [RowWidth-1:0] ROW_ONE     = RowWidth'(1);

  // Serial front end
  logic       sclk_q;
  logic [6:0] shift_q;
  logic [2:0] bitcnt_q;
  logic       frame_err_q;
  logic       cap_edge;
  logic       byte_vld;
  logic [7:0] rx_byte;

  assign cap_edge = SCLK & ~sclk_q & ~nCS;
  assign byte_vld = cap_edge && (bitcnt_q == 3'd7);
  assign rx_byte  = {shift_q, SDIN};

  // sclk_q resets high so a bus left with SCLK high never yields a false edge at release.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sclk_q      <= 1'b1;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_q <= SCLK;
      if (nCS) begin
        bitcnt_q <= '0;
      end else if (cap_edge) begin
        shift_q  <= {shift_q[5:0], SDIN};
        bitcnt_q <= bitcnt_q + 3'd1;
      end
      if (nCS && (bitcnt_q != 3'd0)) begin
        frame_err_q <= 1'b1;
      end else if (err_clear) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  // Decode state, address window and cursor
  state_e              state_q, state_d;
  logic [ColWidth-1:0] x_start_q, x_start_d, x_end_q, x_end_d;
  logic [RowWidth-1:0] y_start_q, y_start_d, y_end_q, y_end_d;
  logic [ColWidth-1:0] cur_x_q, cur_x_d;
  logic [RowWidth-1:0] cur_y_q, cur_y_d;
  logic [7:0]          hi_q, hi_d;

  logic                pix_valid_q, pix_valid_d;
  logic [ColWidth-1:0] pix_x_q, pix_x_d;
  logic [RowWidth-1:0] pix_y_q, pix_y_d;
  logic [15:0]         pix_colour_q, pix_colour_d;
  logic                window_done_q, window_done_d;

  always_comb begin
    state_d       = state_q;
    x_start_d     = x_start_q;
    x_end_d       = x_end_q;
    y_start_d     = y_start_q;
    y_end_d       = y_end_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    hi_d          = hi_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_colour_d  = pix_colour_q;
    window_done_d = 1'b0;

    if (byte_vld) begin
      if (!DnC) begin
        // Commands abort whatever sequence is in progress, from any state.
        case (rx_byte)
          CMD_SETX:   state_d = ST_XSTART;
          CMD_SETY:   state_d = ST_YSTART;
          CMD_SETPIX: begin
            state_d = ST_PIXHI;
            cur_x_d = x_start_q;
            cur_y_d = y_start_q;
          end
          default:    state_d = ST_IDLE;
        endcase
      end else begin
        case (state_q)
          ST_XSTART: begin
            x_start_d = rx_byte[ColWidth-1:0];
            state_d   = ST_XEND;
          end
          ST_XEND: begin
            x_end_d = rx_byte[ColWidth-1:0];
            state_d = ST_IDLE;
          end
          ST_YSTART: begin
            y_start_d = rx_byte[RowWidth-1:0];
            state_d   = ST_YEND;
          end
          ST_YEND: begin
            y_end_d = rx_byte[RowWidth-1:0];
            state_d = ST_IDLE;
          end
          ST_PIXHI: begin
            hi_d    = rx_byte;
            state_d = ST_PIXLO;
          end
          ST_PIXLO: begin
            pix_valid_d   = 1'b1;
            pix_x_d       = cur_x_q;
            pix_y_d       = cur_y_q;
            pix_colour_d  = {hi_q, rx_byte};
            window_done_d = (cur_x_q == x_end_q) && (cur_y_q == y_end_q);
            state_d       = ST_PIXHI;
            // Equality-only wrap lets a reversed window roll through the maximum.
            if (cur_x_q == x_end_q) begin
              cur_x_d = x_start_q;
              cur_y_d = (cur_y_q == y_end_q) ? y_start_q : cur_y_q + ROW_ONE;
            end else begin
              cur_x_d = cur_x_q + COL_ONE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= ST_IDLE;
      x_start_q     <= '0;
      x_end_q       <= COL_END_RST;
      y_start_q     <= '0;
      y_end_q       <= ROW_END_RST;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      hi_q          <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_colour_q  <= '0;
      window_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_start_q     <= x_start_d;
      x_end_q       <= x_end_d;
      y_start_q     <= y_start_d;
      y_end_q       <= y_end_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      hi_q          <= hi_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_colour_q  <= pix_colour_d;
      window_done_q <= window_done_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_colour  = pix_colour_q;
  assign window_done = window_done_q;
  assign frame_err   = frame_err_q;

endmodule
